// File: rtl/dataflow_sequencer_if.sv
// dataflow_sequencer_if
//   Bundles the sequencer's stall input, external data bus and the per-cycle
//   control outputs into one interface.
//   master : the sequencer (consumes ready/data_bus_in, drives the rest)
//   slave  : the surrounding datapath / testbench
//   Signals: ready, data_bus_in[7:0], flags[FLAG_W-1:0], timing_state[T_W-1:0],
//            sync, write_en, instr_done, illegal_op, halted
interface dataflow_sequencer_if #(
  parameter int FLAG_W = 41,
  parameter int T_W    = 3
);
  logic              ready;
  logic [7:0]        data_bus_in;
  logic [FLAG_W-1:0] flags;
  logic [T_W-1:0]    timing_state;
  logic              sync;
  logic              write_en;
  logic              instr_done;
  logic              illegal_op;
  logic              halted;

  modport master (
    input  ready, data_bus_in,
    output flags, timing_state, sync, write_en, instr_done, illegal_op, halted
  );

  modport slave (
    output ready, data_bus_in,
    input  flags, timing_state, sync, write_en, instr_done, illegal_op, halted
  );
endinterface

// File: rtl/dataflow_sequencer.sv
// dataflow_sequencer
//   Timing-state controller: latches the opcode from the data bus at the end
//   of T1 and steps T0..T4, producing one control flag word per clock for the
//   address registers, ALU hold register, A/X/Y and the memory write strobe.
//   Handles register transfers, immediate/zero-page/absolute loads and
//   zero-page/absolute stores.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous reset, active high (state T0, IR = 0xEA)
//   bus  - dataflow_sequencer_if.master: ready, data_bus_in -> flags,
//          timing_state, sync, write_en, instr_done, illegal_op, halted
// Build option:
//   ILLEGAL_TRAP_EN - when defined, an undecoded opcode sends the sequencer to
//   a HALT state after T1 (halted=1, exit only via rst; timing_state reads 5).
//   When undefined, undecoded opcodes run as a 3-cycle NOP and halted is 0.
module dataflow_sequencer #(
  parameter int FLAG_W = 41,
  parameter int T_W    = 3
) (
  input logic                  clk,
  input logic                  rst,
  dataflow_sequencer_if.master bus
);

  // Flag bit positions within the shared control word.
  localparam int F_SET_ADL_TO_PCL = 0;
  localparam int F_SET_ADH_TO_PCH = 1;
  localparam int F_LOAD_ABL       = 2;
  localparam int F_LOAD_ABH       = 3;
  localparam int F_INC_PC         = 4;
  localparam int F_SET_SB_TO_ACC  = 5;
  localparam int F_SET_SB_TO_X    = 6;
  localparam int F_SET_SB_TO_Y    = 7;
  localparam int F_SET_SB_TO_DB   = 8;
  localparam int F_LOAD_ACC       = 9;
  localparam int F_LOAD_X         = 10;
  localparam int F_LOAD_Y         = 11;
  localparam int F_SET_ADL_TO_DB  = 12;
  localparam int F_ZERO_ADH       = 13;
  localparam int F_LOAD_ALU       = 14;
  localparam int F_SET_ADL_TO_ALU = 15;
  localparam int F_SET_ADH_TO_DB  = 16;
  localparam int F_SET_DB_TO_SB   = 17;

  localparam logic [FLAG_W-1:0] ONE = FLAG_W'(1);
  // PC onto the address registers (opcode / operand fetch address).
  localparam logic [FLAG_W-1:0] PC_FLAGS = (ONE << F_SET_ADL_TO_PCL) | (ONE << F_SET_ADH_TO_PCH) |
                                           (ONE << F_LOAD_ABL) | (ONE << F_LOAD_ABH);

  typedef enum logic [2:0] {
    ST_T0   = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_HALT = 3'd5
  } state_t;

  typedef enum logic [2:0] {CL_IMPL, CL_IMM, CL_ZP, CL_ABS, CL_ILL} class_t;

  function automatic class_t decode_class(input logic [7:0] op);
    class_t c;
    case (op)
      8'hAA, 8'h8A, 8'hA8, 8'h98, 8'hEA:         c = CL_IMPL;
      8'hA9, 8'hA2, 8'hA0:                       c = CL_IMM;
      8'hA5, 8'hA6, 8'hA4, 8'h85, 8'h86, 8'h84:  c = CL_ZP;
      8'hAD, 8'hAE, 8'hAC, 8'h8D, 8'h8E, 8'h8C:  c = CL_ABS;
      default:                                   c = CL_ILL;
    endcase
    return c;
  endfunction

  state_t            state_reg, state_next;
  logic [7:0]        ir_reg;
  class_t            ir_class, bus_class;
  logic              active;
  logic              is_store;
  logic [1:0]        reg_sel;
  logic [FLAG_W-1:0] load_flags, src_flags, mem_flags, flags_raw;
  logic              we_raw, done_raw, ill_raw, halt_entry;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_T0;
      ir_reg    <= 8'hEA;
    end else if (bus.ready) begin
      state_reg <= state_next;
      if (state_reg == ST_T1) ir_reg <= bus.data_bus_in;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic halt_entry_reg;
  // Marks the first HALT cycle so illegal_op pulses exactly once on entry.
  always_ff @(posedge clk) begin
    if (rst)            halt_entry_reg <= 1'b0;
    else if (bus.ready) halt_entry_reg <= (state_reg == ST_T1) && (state_next == ST_HALT);
  end
  assign halt_entry = halt_entry_reg;
`else
  assign halt_entry = 1'b0;
`endif

  assign ir_class  = decode_class(ir_reg);
  assign bus_class = decode_class(bus.data_bus_in);
  assign active    = bus.ready & ~rst;

  // Load/store opcodes encode the register in the low two bits:
  // 01 = A, 10 = X, 00 = Y. Stores are the 0x8x row.
  assign reg_sel  = ir_reg[1:0];
  assign is_store = (ir_reg[7:5] == 3'b100);

  always_comb begin
    load_flags = '0;
    src_flags  = '0;
    load_flags[F_LOAD_ACC]      = (reg_sel == 2'b01);
    load_flags[F_LOAD_X]        = (reg_sel == 2'b10);
    load_flags[F_LOAD_Y]        = (reg_sel == 2'b00);
    src_flags[F_SET_SB_TO_ACC]  = (reg_sel == 2'b01);
    src_flags[F_SET_SB_TO_X]    = (reg_sel == 2'b10);
    src_flags[F_SET_SB_TO_Y]    = (reg_sel == 2'b00);
    // Memory-data cycle: a load routes DB->SB->reg, a store routes reg->SB->DB.
    if (is_store) mem_flags = src_flags | (ONE << F_SET_DB_TO_SB);
    else          mem_flags = load_flags | (ONE << F_SET_SB_TO_DB);
  end

  always_comb begin
    state_next = state_reg;
    flags_raw  = '0;
    we_raw     = 1'b0;
    done_raw   = 1'b0;
    ill_raw    = 1'b0;
    case (state_reg)
      ST_T0: begin
        flags_raw           = PC_FLAGS;
        flags_raw[F_INC_PC] = 1'b1;
        state_next          = ST_T1;
      end
      ST_T1: begin
        // Implied (and undecoded) opcodes have no operand byte to step over.
        flags_raw           = PC_FLAGS;
        flags_raw[F_INC_PC] = (bus_class != CL_IMPL) && (bus_class != CL_ILL);
        state_next          = ST_T2;
`ifdef ILLEGAL_TRAP_EN
        if (bus_class == CL_ILL) state_next = ST_HALT;
`endif
      end
      ST_T2: begin
        case (ir_class)
          CL_IMPL: begin
            case (ir_reg)
              8'hAA:   flags_raw = (ONE << F_SET_SB_TO_ACC) | (ONE << F_LOAD_X);
              8'h8A:   flags_raw = (ONE << F_SET_SB_TO_X)   | (ONE << F_LOAD_ACC);
              8'hA8:   flags_raw = (ONE << F_SET_SB_TO_ACC) | (ONE << F_LOAD_Y);
              8'h98:   flags_raw = (ONE << F_SET_SB_TO_Y)   | (ONE << F_LOAD_ACC);
              default: flags_raw = '0;
            endcase
            done_raw   = 1'b1;
            state_next = ST_T0;
          end
          CL_IMM: begin
            flags_raw  = load_flags | (ONE << F_SET_SB_TO_DB);
            done_raw   = 1'b1;
            state_next = ST_T0;
          end
          CL_ZP: begin
            flags_raw  = (ONE << F_SET_ADL_TO_DB) | (ONE << F_ZERO_ADH) |
                         (ONE << F_LOAD_ABL) | (ONE << F_LOAD_ABH);
            state_next = ST_T3;
          end
          CL_ABS: begin
            // Low address byte parks in the ALU hold register while the PC
            // fetches the high byte.
            flags_raw  = PC_FLAGS | (ONE << F_INC_PC) | (ONE << F_SET_SB_TO_DB) | (ONE << F_LOAD_ALU);
            state_next = ST_T3;
          end
          default: begin
            ill_raw    = 1'b1;
            done_raw   = 1'b1;
            state_next = ST_T0;
          end
        endcase
      end
      ST_T3: begin
        if (ir_class == CL_ABS) begin
          flags_raw  = (ONE << F_SET_ADL_TO_ALU) | (ONE << F_SET_ADH_TO_DB) |
                       (ONE << F_LOAD_ABL) | (ONE << F_LOAD_ABH);
          state_next = ST_T4;
        end else begin
          flags_raw  = mem_flags;
          we_raw     = is_store;
          done_raw   = 1'b1;
          state_next = ST_T0;
        end
      end
      ST_T4: begin
        flags_raw  = mem_flags;
        we_raw     = is_store;
        done_raw   = 1'b1;
        state_next = ST_T0;
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_T0;
    endcase
  end

  // Stall or reset blanks the whole flag word.
  for (genvar gi = 0; gi < FLAG_W; gi++) begin : g_flag_gate
    assign bus.flags[gi] = flags_raw[gi] & active;
  end

  assign bus.timing_state = T_W'(state_reg);
  assign bus.sync         = (state_reg == ST_T0) & ~rst;
  assign bus.write_en     = we_raw & active;
  assign bus.instr_done   = done_raw & active;
  assign bus.illegal_op   = (ill_raw | halt_entry) & active;
`ifdef ILLEGAL_TRAP_EN
  assign bus.halted       = (state_reg == ST_HALT) & ~rst;
`else
  assign bus.halted       = 1'b0;
`endif

  a_sb_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0({bus.flags[F_SET_SB_TO_ACC], bus.flags[F_SET_SB_TO_X],
              bus.flags[F_SET_SB_TO_Y], bus.flags[F_SET_SB_TO_DB]}));

  a_we_no_load: assert property (@(posedge clk) disable iff (rst)
    bus.write_en |-> !(bus.flags[F_LOAD_ACC] || bus.flags[F_LOAD_X] || bus.flags[F_LOAD_Y]));

endmodule

// File: tb/tb_dataflow_sequencer.sv
// tb_dataflow_sequencer
//   Table of directed cycle vectors, hand-written reset/trap sequences, then
//   randomized opcodes and stalls checked against an opcode-table model.
module tb_dataflow_sequencer;
  localparam int FLAG_W = 41;
  localparam int T_W    = 3;

  typedef logic [FLAG_W-1:0] fw_t;

  localparam fw_t PCL     = fw_t'(1) << 0;
  localparam fw_t PCH     = fw_t'(1) << 1;
  localparam fw_t ABL     = fw_t'(1) << 2;
  localparam fw_t ABH     = fw_t'(1) << 3;
  localparam fw_t INC     = fw_t'(1) << 4;
  localparam fw_t SB_A    = fw_t'(1) << 5;
  localparam fw_t SB_X    = fw_t'(1) << 6;
  localparam fw_t SB_Y    = fw_t'(1) << 7;
  localparam fw_t SB_DB   = fw_t'(1) << 8;
  localparam fw_t L_A     = fw_t'(1) << 9;
  localparam fw_t L_X     = fw_t'(1) << 10;
  localparam fw_t L_Y     = fw_t'(1) << 11;
  localparam fw_t ADL_DB  = fw_t'(1) << 12;
  localparam fw_t Z_ADH   = fw_t'(1) << 13;
  localparam fw_t L_ALU   = fw_t'(1) << 14;
  localparam fw_t ADL_ALU = fw_t'(1) << 15;
  localparam fw_t ADH_DB  = fw_t'(1) << 16;
  localparam fw_t DB_SB   = fw_t'(1) << 17;
  localparam fw_t PC      = PCL | PCH | ABL | ABH;

  typedef struct packed {
    logic [2:0] ts;
    fw_t        flags;
    logic       sync;
    logic       we;
    logic       done;
    logic       ill;
    logic       halted;
  } exp_t;

  typedef struct {
    string      nm;
    logic       rdy;
    logic [7:0] d;
    exp_t       e;
  } vec_t;

  typedef enum {C_IMPL, C_IMM, C_ZP, C_ABS, C_ILL} cls_e;
  typedef struct {
    cls_e cls;
    int   r;      // 0 = A, 1 = X, 2 = Y
    bit   store;
  } info_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  vec_t       tbl[$];
  exp_t       exp_q[$];
  info_t      info_tab[256];
  fw_t        impl_flags[256];
  logic [7:0] legal_ops[$];

  dataflow_sequencer_if #(.FLAG_W(FLAG_W), .T_W(T_W)) bus ();
  dataflow_sequencer #(.FLAG_W(FLAG_W), .T_W(T_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic exp_t ex(input int ts, input fw_t f, input bit we, input bit done, input bit ill);
    exp_t e;
    e.ts = 3'(ts); e.flags = f; e.sync = (ts == 0); e.we = we; e.done = done; e.ill = ill; e.halted = 1'b0;
    return e;
  endfunction

  function automatic exp_t stall(input int ts);
    return ex(ts, '0, 0, 0, 0);
  endfunction

  function automatic exp_t zero_out();
    exp_t e;
    e = '0;
    return e;
  endfunction

  function automatic void add(input string nm, input logic rdy, input logic [7:0] d, input exp_t e);
    vec_t v;
    v.nm = nm; v.rdy = rdy; v.d = d; v.e = e;
    tbl.push_back(v);
  endfunction

  function automatic void set_info(input logic [7:0] op, input cls_e c, input int r, input bit s);
    info_tab[op].cls = c; info_tab[op].r = r; info_tab[op].store = s;
    legal_ops.push_back(op);
  endfunction

  function automatic void init_model();
    for (int i = 0; i < 256; i++) begin
      info_tab[i].cls = C_ILL; info_tab[i].r = 0; info_tab[i].store = 0;
      impl_flags[i] = '0;
    end
    set_info(8'hAA, C_IMPL, 0, 0); impl_flags[8'hAA] = SB_A | L_X;
    set_info(8'h8A, C_IMPL, 0, 0); impl_flags[8'h8A] = SB_X | L_A;
    set_info(8'hA8, C_IMPL, 0, 0); impl_flags[8'hA8] = SB_A | L_Y;
    set_info(8'h98, C_IMPL, 0, 0); impl_flags[8'h98] = SB_Y | L_A;
    set_info(8'hEA, C_IMPL, 0, 0);
    set_info(8'hA9, C_IMM, 0, 0); set_info(8'hA2, C_IMM, 1, 0); set_info(8'hA0, C_IMM, 2, 0);
    set_info(8'hA5, C_ZP, 0, 0);  set_info(8'hA6, C_ZP, 1, 0);  set_info(8'hA4, C_ZP, 2, 0);
    set_info(8'h85, C_ZP, 0, 1);  set_info(8'h86, C_ZP, 1, 1);  set_info(8'h84, C_ZP, 2, 1);
    set_info(8'hAD, C_ABS, 0, 0); set_info(8'hAE, C_ABS, 1, 0); set_info(8'hAC, C_ABS, 2, 0);
    set_info(8'h8D, C_ABS, 0, 1); set_info(8'h8E, C_ABS, 1, 1); set_info(8'h8C, C_ABS, 2, 1);
  endfunction

  // Expected active cycles of one instruction, from its class and register.
  function automatic void build(input logic [7:0] op);
    info_t inf;
    fw_t   ld, src, mem;
    inf = info_tab[op];
    ld  = (inf.r == 0) ? L_A : (inf.r == 1) ? L_X : L_Y;
    src = (inf.r == 0) ? SB_A : (inf.r == 1) ? SB_X : SB_Y;
    mem = inf.store ? (src | DB_SB) : (SB_DB | ld);
    exp_q.delete();
    exp_q.push_back(ex(0, PC | INC, 0, 0, 0));
    exp_q.push_back(ex(1, (inf.cls == C_IMPL || inf.cls == C_ILL) ? PC : (PC | INC), 0, 0, 0));
    case (inf.cls)
      C_IMPL: exp_q.push_back(ex(2, impl_flags[op], 0, 1, 0));
      C_IMM:  exp_q.push_back(ex(2, SB_DB | ld, 0, 1, 0));
      C_ZP: begin
        exp_q.push_back(ex(2, ADL_DB | Z_ADH | ABL | ABH, 0, 0, 0));
        exp_q.push_back(ex(3, mem, inf.store, 1, 0));
      end
      C_ABS: begin
        exp_q.push_back(ex(2, SB_DB | L_ALU | PC | INC, 0, 0, 0));
        exp_q.push_back(ex(3, ADL_ALU | ADH_DB | ABL | ABH, 0, 0, 0));
        exp_q.push_back(ex(4, mem, inf.store, 1, 0));
      end
      default: exp_q.push_back(ex(2, '0, 0, 1, 1));
    endcase
  endfunction

  task automatic check(input string nm, input exp_t e, input bit chk_ts);
    exp_t got;
    got.ts = bus.timing_state; got.flags = bus.flags; got.sync = bus.sync; got.we = bus.write_en;
    got.done = bus.instr_done; got.ill = bus.illegal_op; got.halted = bus.halted;
    if (!chk_ts) got.ts = e.ts;
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL %s: got ts=%0d flags=%h sync=%b we=%b done=%b ill=%b halted=%b, expected ts=%0d flags=%h sync=%b we=%b done=%b ill=%b halted=%b",
               nm, got.ts, got.flags, got.sync, got.we, got.done, got.ill, got.halted,
               e.ts, e.flags, e.sync, e.we, e.done, e.ill, e.halted);
    end
  endtask

  // One clock: drive at the falling edge, compare 1 time unit later.
  task automatic cyc(input string nm, input logic rdy, input logic [7:0] d, input exp_t e, input bit chk_ts);
    bus.ready = rdy;
    bus.data_bus_in = d;
    #1;
    check(nm, e, chk_ts);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [7:0] op;
    init_model();

    // Directed cycle table, starting at the first post-reset cycle.
    add("tax_t0", 1, 8'h00, ex(0, PC | INC, 0, 0, 0));
    add("tax_t1", 1, 8'hAA, ex(1, PC, 0, 0, 0));
    add("tax_t2", 1, 8'h00, ex(2, SB_A | L_X, 0, 1, 0));
    add("ldx_t0", 1, 8'h00, ex(0, PC | INC, 0, 0, 0));
    add("ldx_t1", 1, 8'hA2, ex(1, PC | INC, 0, 0, 0));
    add("ldx_t2", 1, 8'h5C, ex(2, SB_DB | L_X, 0, 1, 0));
    add("sta_abs_t0", 1, 8'h00, ex(0, PC | INC, 0, 0, 0));
    add("sta_abs_t1", 1, 8'h8D, ex(1, PC | INC, 0, 0, 0));
    add("sta_abs_t2", 1, 8'h34, ex(2, SB_DB | L_ALU | PC | INC, 0, 0, 0));
    add("sta_abs_t3", 1, 8'h12, ex(3, ADL_ALU | ADH_DB | ABL | ABH, 0, 0, 0));
    add("sta_abs_t4", 1, 8'h00, ex(4, SB_A | DB_SB, 1, 1, 0));
    add("lda_zp_t0", 1, 8'h00, ex(0, PC | INC, 0, 0, 0));
    add("lda_zp_t1", 1, 8'hA5, ex(1, PC | INC, 0, 0, 0));
    add("lda_zp_stall1", 0, 8'h40, stall(2));
    add("lda_zp_stall2", 0, 8'h40, stall(2));
    add("lda_zp_stall3", 0, 8'h40, stall(2));
    add("lda_zp_t2", 1, 8'h40, ex(2, ADL_DB | Z_ADH | ABL | ABH, 0, 0, 0));
    add("lda_zp_t3", 1, 8'h77, ex(3, SB_DB | L_A, 0, 1, 0));
    add("sty_zp_t0_stall", 0, 8'h00, stall(0));
    add("sty_zp_t0", 1, 8'h00, ex(0, PC | INC, 0, 0, 0));
    add("sty_zp_t1", 1, 8'h84, ex(1, PC | INC, 0, 0, 0));
    add("sty_zp_t2", 1, 8'h10, ex(2, ADL_DB | Z_ADH | ABL | ABH, 0, 0, 0));
    add("sty_zp_t3", 1, 8'h00, ex(3, SB_Y | DB_SB, 1, 1, 0));
    add("nop_t0", 1, 8'h00, ex(0, PC | INC, 0, 0, 0));
    add("nop_t1_stall", 0, 8'hA9, stall(1));
    add("nop_t1", 1, 8'hEA, ex(1, PC, 0, 0, 0));
    add("nop_t2", 1, 8'hA9, ex(2, '0, 0, 1, 0));
    add("txa_t0", 1, 8'h00, ex(0, PC | INC, 0, 0, 0));
    add("txa_t1", 1, 8'h8A, ex(1, PC, 0, 0, 0));
    add("txa_t2", 1, 8'h00, ex(2, SB_X | L_A, 0, 1, 0));
`ifndef ILLEGAL_TRAP_EN
    add("ill_t0", 1, 8'h00, ex(0, PC | INC, 0, 0, 0));
    add("ill_t1", 1, 8'h02, ex(1, PC, 0, 0, 0));
    add("ill_t2", 1, 8'h00, ex(2, '0, 0, 1, 1));
    add("ill_next_t0", 1, 8'h00, ex(0, PC | INC, 0, 0, 0));
    add("ill_next_t1", 1, 8'hEA, ex(1, PC, 0, 0, 0));
    add("ill_next_t2", 1, 8'h00, ex(2, '0, 0, 1, 0));
`endif

    // Reset: outputs quiet while rst is high.
    bus.ready = 1'b1;
    bus.data_bus_in = 8'h00;
    rst = 1'b1;
    #1;
    check("reset_c1", zero_out(), 0);
    @(negedge clk);
    #1;
    check("reset_c2", zero_out(), 1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i].nm, tbl[i].rdy, tbl[i].d, tbl[i].e, 1);

    // Reset in the middle of STA zp: no write strobe, restart at T0.
    cyc("rstmid_t0", 1, 8'h00, ex(0, PC | INC, 0, 0, 0), 1);
    cyc("rstmid_t1", 1, 8'h85, ex(1, PC | INC, 0, 0, 0), 1);
    rst = 1'b1;
    cyc("rstmid_in_reset", 1, 8'h20, zero_out(), 0);
    rst = 1'b0;
    cyc("rstmid_after_t0", 1, 8'h00, ex(0, PC | INC, 0, 0, 0), 1);
    cyc("rstmid_after_t1", 1, 8'hEA, ex(1, PC, 0, 0, 0), 1);
    cyc("rstmid_after_t2", 1, 8'h00, ex(2, '0, 0, 1, 0), 1);

`ifdef ILLEGAL_TRAP_EN
    cyc("trap_t0", 1, 8'h00, ex(0, PC | INC, 0, 0, 0), 1);
    cyc("trap_t1", 1, 8'h02, ex(1, PC, 0, 0, 0), 1);
    e = zero_out();
    e.halted = 1'b1;
    e.ill = 1'b1;
    cyc("trap_halt_entry", 1, 8'h00, e, 0);
    e.ill = 1'b0;
    for (int k = 0; k < 9; k++) cyc($sformatf("trap_halt_%0d", k), 1, 8'(k), e, 0);
    rst = 1'b1;
    cyc("trap_reset", 1, 8'h00, zero_out(), 0);
    rst = 1'b0;
`endif

    // Randomized instructions and stalls against the opcode-table model.
    for (int n = 0; n < 200; n++) begin
`ifdef ILLEGAL_TRAP_EN
      op = legal_ops[$urandom_range(0, legal_ops.size() - 1)];
`else
      if ($urandom_range(0, 9) == 0) op = 8'($urandom);
      else op = legal_ops[$urandom_range(0, legal_ops.size() - 1)];
`endif
      build(op);
      for (int k = 0; k < exp_q.size(); k++) begin
        int stalls;
        stalls = 0;
        while (stalls < 3 && $urandom_range(0, 4) == 0) begin
          cyc($sformatf("rnd%0d_op%02h_stall_t%0d", n, op, exp_q[k].ts), 0, 8'($urandom), stall(int'(exp_q[k].ts)), 1);
          stalls++;
        end
        cyc($sformatf("rnd%0d_op%02h_t%0d", n, op, exp_q[k].ts), 1,
            (exp_q[k].ts == 3'd1) ? op : 8'($urandom), exp_q[k], 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dataflow_sequencer.md
Name: dataflow_sequencer

Overview:
- Timing-state controller that drives the internal dataflow control flag vector, one flag word per clock.
- Latches the opcode from the external data bus and steps timing states T0..T4.
- Emits load/drive flags for the address-bus, ALU, accumulator, X and Y registers, plus the memory write strobe.
- Covers the first instruction subset: register transfers, immediate/zero-page/absolute loads, and zero-page/absolute stores.

Parameters:
- FLAG_W, 41: width of the flag vector; indices come from the shared constants file.
- T_W, 3: width of the timing-state encoding.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- ready  in  1  stall input; 0 freezes the sequencer.
- data_bus_in  in  8  external data bus, valid the cycle after the address registers load.
- flags  out  FLAG_W  control flag word for the current cycle.
- timing_state  out  T_W  current T state (0..4).
- sync  out  1  high during T0 (opcode address cycle).
- write_en  out  1  memory write strobe.
- instr_done  out  1  high in the final cycle of an instruction.
- illegal_op  out  1  one-cycle pulse on an undecoded opcode.
- halted  out  1  trap indicator; tied 0 when ILLEGAL_TRAP_EN is undefined.

Behaviour:
- Reset:
  - While rst=1: state T0, IR=0xEA (NOP).
  - Outputs during reset: flags all 0, sync=0, write_en=0, instr_done=0, illegal_op=0, halted=0.
  - The first cycle after rst deasserts is T0 with sync=1.
  - rst mid-instruction aborts the instruction; no partial writeback occurs after the reset edge.
- ready=0: state, IR and the ALU-hold sequencing freeze; flags, write_en, instr_done and illegal_op forced to 0. Execution resumes in the same T state when ready returns to 1.
- T0 (all instructions): SET_ADL_TO_PCL, SET_ADH_TO_PCH, LOAD_ABL, LOAD_ABH, INC_PC; sync=1.
- T1 (all instructions):
  - IR <= data_bus_in at the clock edge ending T1.
  - Present the PC on the address registers again (operand fetch), same flags as T0.
  - INC_PC only when the decoded class is not implied. The class is decoded combinationally from data_bus_in in T1.
- Implied class, 3 cycles; T2 is the final cycle:
  - TAX 0xAA: SET_SB_TO_ACC, LOAD_X.
  - TXA 0x8A: SET_SB_TO_X, LOAD_ACC.
  - TAY 0xA8: SET_SB_TO_ACC, LOAD_Y.
  - TYA 0x98: SET_SB_TO_Y, LOAD_ACC.
  - NOP 0xEA: no flags.
- Immediate class, 3 cycles (LDA 0xA9, LDX 0xA2, LDY 0xA0): T2 asserts SET_SB_TO_DB plus LOAD_ACC, LOAD_X or LOAD_Y.
- Zero-page class, 4 cycles (LDA 0xA5, LDX 0xA6, LDY 0xA4, STA 0x85, STX 0x86, STY 0x84):
  - T2: SET_ADL_TO_DB, ZERO_ADH, LOAD_ABL, LOAD_ABH.
  - T3 load: SET_SB_TO_DB plus the destination load.
  - T3 store: SET_SB_TO_<src>, SET_DB_TO_SB, write_en=1.
- Absolute class, 5 cycles (0xAD, 0xAE, 0xAC, 0x8D, 0x8E, 0x8C):
  - T2: SET_SB_TO_DB, LOAD_ALU (pass-through hold of the low byte), PC address flags, INC_PC.
  - T3: SET_ADL_TO_ALU, SET_ADH_TO_DB, LOAD_ABL, LOAD_ABH.
  - T4: identical to zero-page T3.
- Final cycle of every class: instr_done=1; next state is T0.
- Invariants checked by assertion:
  - At most one SET_SB_TO_* flag asserted in any cycle.
  - write_en never asserted together with any LOAD_* flag for a register sourcing the stack bus.
- Undecoded opcode: illegal_op=1 in T2. The instruction then behaves as NOP (3 cycles).

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an undecoded opcode moves the sequencer to HALT after T1 instead of T2.
  - In HALT: flags=0, write_en=0, sync=0, halted=1, illegal_op pulses once on entry.
  - HALT exits only via rst.
- Undefined: NOP behaviour as above; halted is tied 0.

Test Plan:
- rst=1 for 2 cycles, then 0 -> flags=0 during reset; first post-reset cycle has timing_state=0, sync=1, LOAD_ABL=LOAD_ABH=INC_PC=1.
- data_bus_in=0xAA in T1 -> IR=0xAA; T2 flags exactly {SET_SB_TO_ACC, LOAD_X}, instr_done=1; next cycle is T0.
- 0xA2 then operand 0x5C -> 3 cycles; T2 asserts SET_SB_TO_DB and LOAD_X; INC_PC asserted in T0 and T1 only.
- 0x8D (STA abs) -> 5 cycles; T2 LOAD_ALU; T3 SET_ADL_TO_ALU with SET_ADH_TO_DB; T4 write_en=1 with SET_SB_TO_ACC; instr_done only in T4.
- 0xA5 with ready=0 for 3 cycles during T2 -> timing_state holds 2, flags=0 while stalled; completes T3 after release; 4 active cycles total.
- 0x02 -> illegal_op=1 for one cycle.
  - Without the macro: 3-cycle NOP, then T0.
  - With ILLEGAL_TRAP_EN: halted=1 persists 10 cycles until rst clears it.
